// File: rtl/ahb_ram.sv
// ahb_ram: AHB-Lite RAM responder with WAIT_STATES data-phase wait cycles and read forwarding.
// Define AHB_RAM_ERRRESP_EN to answer illegal transfers with a two-cycle ERROR response.
module ahb_ram #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [1:0]  o_state
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1
`ifdef AHB_RAM_ERRRESP_EN
        , ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
`endif
    } state_t;

    // Handshake: an address phase is taken only on a cycle where HSEL, HREADY,
    // HTRANS[1] and our own HREADYOUT are all high; that same cycle is the final
    // data-phase cycle of the previous transfer (if any).
    state_t                 state_q, state_d;
    logic [2:0]             count_q, count_d;
    logic                   dp_valid_q, dp_valid_d;
    logic                   dp_write_q, dp_write_d;
    logic                   dp_legal_q, dp_legal_d;
    logic [1:0]             dp_size_q, dp_size_d;
    logic [1:0]             dp_lane_q, dp_lane_d;
    logic [ADDR_WIDTH-1:0]  dp_idx_q, dp_idx_d;
    logic [31:0]            hrdata_q, hrdata_d;
    logic [31:0]            mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]  a_idx;
    logic                   a_in_range, a_align_ok, a_legal;
    logic                   ready, accept, wr_en;
    logic [3:0]             be;
    logic [31:0]            wr_word, rd_word;
    logic                   unused_ok;

    assign unused_ok  = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};
    assign a_idx      = HADDR[ADDR_WIDTH+1:2];
    assign a_in_range = HADDR[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];

    always_comb begin
        case (HSIZE)
            3'd0:    a_align_ok = 1'b1;
            3'd1:    a_align_ok = ~HADDR[0];
            3'd2:    a_align_ok = HADDR[1:0] == 2'b00;
            default: a_align_ok = 1'b0;
        endcase
    end

    assign a_legal = a_in_range & a_align_ok;
`ifdef AHB_RAM_ERRRESP_EN
    assign ready   = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign HRESP   = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
    assign ready   = state_q == ST_IDLE;
    assign HRESP   = 1'b0;
`endif
    assign accept    = HSEL & HREADY & HTRANS[1] & ready;
    assign wr_en     = (state_q == ST_IDLE) & dp_valid_q & dp_write_q & dp_legal_q;
    assign HREADYOUT = ready;
    assign HRDATA    = hrdata_q;
    assign o_state   = state_q;

    always_comb begin
        case (dp_size_q)
            2'd0:    be = 4'b0001 << dp_lane_q;
            2'd1:    be = dp_lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Merged write word doubles as the forwarding source for a read of the same word.
    always_comb begin
        wr_word = mem_q[dp_idx_q];
        for (int b = 0; b < 4; b++) begin
            if (be[b]) wr_word[8*b +: 8] = HWDATA[8*b +: 8];
        end
        rd_word = (wr_en && (dp_idx_q == a_idx)) ? wr_word : mem_q[a_idx];
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_legal_d = dp_legal_q;
        dp_size_d  = dp_size_q;
        dp_lane_d  = dp_lane_q;
        dp_idx_d   = dp_idx_q;
        hrdata_d   = hrdata_q;
        if (ready) dp_valid_d = accept;
        if (accept) begin
            dp_write_d = HWRITE;
            dp_legal_d = a_legal;
            dp_size_d  = HSIZE[1:0];
            dp_lane_d  = HADDR[1:0];
            dp_idx_d   = a_idx;
            if (!HWRITE) begin
                if (a_legal) hrdata_d = rd_word;
`ifndef AHB_RAM_ERRRESP_EN
                else hrdata_d = 32'h0;
`endif
            end
        end
        case (state_q)
            ST_WAIT: begin
                if (count_q <= 3'd1) begin
                    state_d = ST_IDLE;
                    count_d = 3'd0;
                end else begin
                    count_d = count_q - 3'd1;
                end
            end
`ifdef AHB_RAM_ERRRESP_EN
            ST_ERR1: state_d = ST_ERR2;
`endif
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
`ifdef AHB_RAM_ERRRESP_EN
                    if (!a_legal) state_d = ST_ERR1;
                    else
`endif
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        count_d = 3'(WAIT_STATES);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            count_q    <= 3'd0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_legal_q <= 1'b0;
            dp_size_q  <= 2'd0;
            dp_lane_q  <= 2'd0;
            dp_idx_q   <= '0;
            hrdata_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_legal_q <= dp_legal_d;
            dp_size_q  <= dp_size_d;
            dp_lane_q  <= dp_lane_d;
            dp_idx_q   <= dp_idx_d;
            hrdata_q   <= hrdata_d;
        end
    end

    // Array contents survive reset; a reset also clears dp_valid_q so no pending write lands.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem_q[dp_idx_q] <= wr_word;
    end
endmodule

// File: tb/tb_ahb_ram.sv
// tb_ahb_ram: drives two ahb_ram instances (0 and 2 wait states) with pipelined random
// AHB-Lite traffic and compares every data phase against a sequential memory model.
`timescale 1ns/1ps
module tb_ahb_ram;
    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int RUN_LIMIT = 4000;
`ifdef AHB_RAM_ERRRESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        hsel [2];
    logic [31:0] haddr [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hsize [2];
    logic        hwrite [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic        hreadyout [2];
    logic        hresp [2];
    logic [1:0]  dbg_state [2];

    ahb_ram #(.WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HSIZE(hsize[0]), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HWRITE(hwrite[0]), .HWDATA(hwdata[0]), .HREADY(hreadyout[0]),
        .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .o_state(dbg_state[0])
    );

    ahb_ram #(.WAIT_STATES(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HSIZE(hsize[1]), .HBURST(3'b001), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HWRITE(hwrite[1]), .HWDATA(hwdata[1]), .HREADY(hreadyout[1]),
        .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .o_state(dbg_state[1])
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          idle;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } op_t;

    op_t         ops [$];
    logic [31:0] ref_mem [2][1024];
    logic [31:0] last_rd [2];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
        if ((a >> 12) != (BASE >> 12)) return 1'b0;
        if (s > 3'd2) return 1'b0;
        return (a % (32'd1 << s)) == 0;
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] a, input logic [2:0] s);
        logic [31:0] r;
        int first;
        r = old;
        first = int'(a % 4);
        for (int b = first; b < first + (1 << s); b++) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic int exp_waits(input int d, input op_t op);
        if (op.idle) return 0;
        if (ERR_EN && !is_legal(op.addr, op.size)) return 1;
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic push_op(input bit idle, input bit wr, input logic [31:0] a,
                           input logic [2:0] s, input logic [31:0] wd);
        op_t op;
        op.idle = idle; op.wr = wr; op.addr = a; op.size = s; op.wdata = wd;
        ops.push_back(op);
    endtask

    // ---------------- driver ----------------
    task automatic drive_ap(input int d, input int i);
        if (i < 0) begin
            hsel[d] = 1'b0; htrans[d] = 2'b00;
        end else if (ops[i].idle) begin
            // IDLE/BUSY while selected, or NONSEQ while deselected: neither is a transfer
            if ($urandom_range(0, 1) == 0) begin
                hsel[d] = 1'b1; htrans[d] = 2'($urandom_range(0, 1));
            end else begin
                hsel[d] = 1'b0; htrans[d] = 2'b10;
            end
            haddr[d] = ops[i].addr; hsize[d] = 3'd2; hwrite[d] = 1'b1;
        end else begin
            hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = ops[i].addr;
            hsize[d] = ops[i].size; hwrite[d] = ops[i].wr;
        end
    endtask

    task automatic run_ops(input int d);
        int  ap, dpi, nxt, waits, budget;
        bit  rdy, err_ill, lg;
        op_t op;
        nxt = 0; dpi = -1; waits = 0; budget = 0;
        ap = (ops.size() > 0) ? 0 : -1;
        if (ap >= 0) nxt = 1;
        drive_ap(d, ap);
        while ((ap >= 0 || dpi >= 0) && budget < RUN_LIMIT) begin
            @(negedge clk);
            rdy = hreadyout[d];
            if (dpi >= 0) begin
                op = ops[dpi];
                lg = is_legal(op.addr, op.size);
                err_ill = !op.idle && ERR_EN && !lg;
                if (!rdy) begin
                    check_eq("wait_too_long", 32'(waits < exp_waits(d, op)), 32'd1);
                    check_eq("resp_in_wait", 32'(hresp[d]), 32'(err_ill));
                end else begin
                    check_eq("wait_count", waits, exp_waits(d, op));
                    check_eq("resp_final", 32'(hresp[d]), 32'(err_ill));
                end
                if (!op.idle && !op.wr && !err_ill)
                    check_eq("rdata", hrdata[d], lg ? ref_mem[d][word_idx(op.addr)] : 32'h0);
                else
                    check_eq("rdata_hold", hrdata[d], last_rd[d]);
            end
            @(posedge clk); #1;
            if (rdy) begin
                if (dpi >= 0 && !ops[dpi].idle) begin
                    op = ops[dpi];
                    lg = is_legal(op.addr, op.size);
                    if (op.wr && lg)
                        ref_mem[d][word_idx(op.addr)] =
                            merge(ref_mem[d][word_idx(op.addr)], op.wdata, op.addr, op.size);
                    if (!op.wr && !(ERR_EN && !lg))
                        last_rd[d] = lg ? ref_mem[d][word_idx(op.addr)] : 32'h0;
                end
                dpi = ap; waits = 0;
                if (dpi >= 0 && !ops[dpi].idle && ops[dpi].wr) hwdata[d] = ops[dpi].wdata;
                if (nxt < ops.size()) begin
                    ap = nxt; nxt++;
                end else begin
                    ap = -1;
                end
                drive_ap(d, ap);
            end else begin
                waits++;
            end
            budget++;
        end
        check_eq("run_done", 32'(ap < 0 && dpi < 0), 32'd1);
    endtask

    task automatic build_ops();
        int idx, sz, kind;
        logic [31:0] a;
        ops.delete();
        for (int i = 0; i < 16; i++) push_op(0, 1, BASE + 32'(i * 4), 3'd2, $urandom);
        push_op(0, 1, BASE + 32'h10, 3'd2, 32'hDEADBEEF);
        push_op(0, 0, BASE + 32'h10, 3'd2, 32'h0);
        push_op(0, 1, BASE + 32'h10, 3'd2, 32'h11223344);
        push_op(0, 1, BASE + 32'h13, 3'd0, 32'h5A5A5A5A);
        push_op(0, 0, BASE + 32'h10, 3'd2, 32'h0);
        push_op(0, 1, BASE + 32'h20, 3'd2, 32'hA5A50F0F);
        push_op(0, 0, BASE + 32'h20, 3'd2, 32'h0);
        push_op(0, 1, 32'h3000_0000, 3'd2, 32'hFFFFFFFF);
        push_op(0, 0, BASE, 3'd2, 32'h0);
        push_op(0, 1, BASE + 32'h12, 3'd2, 32'hFFFFFFFF);
        push_op(0, 0, BASE + 32'h10, 3'd2, 32'h0);
        for (int i = 0; i < 90; i++) begin
            kind = $urandom_range(0, 9);
            idx = $urandom_range(0, 15);
            if (kind == 0) begin
                push_op(1, 0, BASE + 32'(idx * 4), 3'd2, 32'h0);
            end else if (kind == 1) begin
                case ($urandom_range(0, 3))
                    0: push_op(0, $urandom_range(0, 1), 32'h3000_0000 + 32'(idx * 4), 3'd2, $urandom);
                    1: push_op(0, $urandom_range(0, 1), BASE + 32'(idx * 4) + 32'd1, 3'd1, $urandom);
                    2: push_op(0, $urandom_range(0, 1), BASE + 32'(idx * 4) + 32'd2, 3'd2, $urandom);
                    default: push_op(0, $urandom_range(0, 1), BASE + 32'(idx * 4), 3'd3, $urandom);
                endcase
            end else begin
                sz = $urandom_range(0, 2);
                a = BASE + 32'(idx * 4) + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 1));
                push_op(0, $urandom_range(0, 1), a, 3'(sz), $urandom);
            end
        end
        for (int i = 0; i < 16; i++) push_op(0, 0, BASE + 32'(i * 4), 3'd2, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b0; haddr[d] = 32'h0; htrans[d] = 2'b00; hsize[d] = 3'd0;
            hwrite[d] = 1'b0; hwdata[d] = 32'h0; last_rd[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq("reset_hreadyout", 32'(hreadyout[d]), 32'd1);
            check_eq("reset_hresp", 32'(hresp[d]), 32'd0);
            check_eq("reset_hrdata", hrdata[d], 32'h0);
            check_eq("reset_state", 32'(dbg_state[d]), 32'd0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            build_ops();
            run_ops(d);
        end

        // reset during a wait cycle of a write on the two-wait-state instance
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = BASE + 32'h20; hsize[1] = 3'd2; hwrite[1] = 1'b1;
        @(posedge clk); #1;
        hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h1234_5678;
        @(negedge clk);
        check_eq("rst_pre_wait", 32'(hreadyout[1]), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_hreadyout", 32'(hreadyout[1]), 32'd1);
        check_eq("rst_mid_hresp", 32'(hresp[1]), 32'd0);
        check_eq("rst_mid_hrdata", hrdata[1], 32'h0);
        check_eq("rst_mid_state", 32'(dbg_state[1]), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        @(posedge clk); #1;
        ops.delete();
        push_op(0, 0, BASE + 32'h20, 3'd2, 32'h0);
        push_op(0, 0, BASE + 32'h24, 3'd2, 32'h0);
        run_ops(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
